// File: rtl/alu_op_issue_pkg.sv
// Shared constants and types for the ALU decode/issue stage: ALU opcodes,
// MIPS opcode/funct encodings and the stored issue-entry layout.
package alu_op_issue_pkg;

  localparam int unsigned XLEN  = 32;
  localparam logic [1:0]  DEPTH = 2'd2;

  typedef enum logic [5:0] {
    ALU_ADD  = 6'h00, ALU_ADDU = 6'h01, ALU_SUB  = 6'h02, ALU_SUBU = 6'h03,
    ALU_SLL  = 6'h04, ALU_SLLV = 6'h05, ALU_SRA  = 6'h06, ALU_SRAV = 6'h07,
    ALU_SRL  = 6'h08, ALU_SRLV = 6'h09, ALU_AND  = 6'h0A, ALU_OR   = 6'h0B,
    ALU_XOR  = 6'h0C, ALU_NOR  = 6'h0D, ALU_SLT  = 6'h0E, ALU_SLTU = 6'h0F,
    ALU_SGT  = 6'h10, ALU_SGTU = 6'h11, ALU_LUI  = 6'h12, ALU_JUMP = 6'h13,
    ALU_NOP  = 6'h3F
  } alu_op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    alu_op_e          alu_control;
    logic [XLEN-1:0]  src0;
    logic [XLEN-1:0]  src1;
    logic             ov_en;
    logic             illegal;
  } issue_entry_t;

  localparam issue_entry_t ENTRY_RESET =
    '{alu_control: ALU_NOP, src0: 32'h0, src1: 32'h0, ov_en: 1'b0, illegal: 1'b0};
  localparam issue_entry_t ENTRY_ILLEGAL =
    '{alu_control: ALU_NOP, src0: 32'h0, src1: 32'h0, ov_en: 1'b0, illegal: 1'b1};

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/alu_op_issue_if.sv
// Upstream fetch/regfile side and downstream ALU side of the issue stage.
interface alu_op_issue_if;
  import alu_op_issue_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      ALU_control;
  logic [XLEN-1:0] src0;
  logic [XLEN-1:0] src1;
  logic            ov_en;
  logic            illegal;

  modport slave (
    input  in_valid, instr, pc, rs_data, rt_data, out_ready,
    output in_ready, out_valid, ALU_control, src0, src1, ov_en, illegal
  );

  modport master (
    output in_valid, instr, pc, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, ALU_control, src0, src1, ov_en, illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational MIPS-to-ALU decode: opcode selection plus operand select/extend.
module alu_op_decode
  import alu_op_issue_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic [31:0]  pc,
  input  logic [31:0]  rs_data,
  input  logic [31:0]  rt_data,
  output issue_entry_t entry
);

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [15:0] imm_s;
  logic [31:0] shamt_s;

  assign opcode_s = instr[31:26];
  assign funct_s  = instr[5:0];
  assign imm_s    = instr[15:0];
  assign shamt_s  = {27'h0, instr[10:6]};

  // Map the instruction to an ALU opcode and its two operands
  always_comb begin
    entry = ENTRY_ILLEGAL;
    case (opcode_s)
      OPC_RTYPE: begin
        entry.illegal = 1'b0;
        entry.src0    = rs_data;
        entry.src1    = rt_data;
        case (funct_s)
          FN_SLL:  begin entry.alu_control = ALU_SLL; entry.src0 = shamt_s; end
          FN_SRL:  begin entry.alu_control = ALU_SRL; entry.src0 = shamt_s; end
          FN_SRA:  begin entry.alu_control = ALU_SRA; entry.src0 = shamt_s; end
          FN_SLLV: entry.alu_control = ALU_SLLV;
          FN_SRLV: entry.alu_control = ALU_SRLV;
          FN_SRAV: entry.alu_control = ALU_SRAV;
          FN_ADD:  begin entry.alu_control = ALU_ADD; entry.ov_en = 1'b1; end
          FN_ADDU: entry.alu_control = ALU_ADDU;
          FN_SUB:  begin entry.alu_control = ALU_SUB; entry.ov_en = 1'b1; end
          FN_SUBU: entry.alu_control = ALU_SUBU;
          FN_AND:  entry.alu_control = ALU_AND;
          FN_OR:   entry.alu_control = ALU_OR;
          FN_XOR:  entry.alu_control = ALU_XOR;
          FN_NOR:  entry.alu_control = ALU_NOR;
          FN_SLT:  entry.alu_control = ALU_SLT;
          FN_SLTU: entry.alu_control = ALU_SLTU;
          default: entry = ENTRY_ILLEGAL;
        endcase
      end
      OPC_J, OPC_JAL: begin
        entry.illegal     = 1'b0;
        entry.alu_control = ALU_JUMP;
        entry.src0        = pc + 32'd4;
        entry.src1        = {4'h0, instr[25:0], 2'b00};
      end
      OPC_ADDI: begin
        entry.illegal     = 1'b0;
        entry.alu_control = ALU_ADD;
        entry.ov_en       = 1'b1;
        entry.src0        = rs_data;
        entry.src1        = sext16(imm_s);
      end
      OPC_ADDIU: begin
        entry.illegal     = 1'b0;
        entry.alu_control = ALU_ADDU;
        entry.src0        = rs_data;
        entry.src1        = sext16(imm_s);
      end
      OPC_SLTI: begin
        entry.illegal     = 1'b0;
        entry.alu_control = ALU_SLT;
        entry.src0        = rs_data;
        entry.src1        = sext16(imm_s);
      end
      OPC_SLTIU: begin
        entry.illegal     = 1'b0;
        entry.alu_control = ALU_SLTU;
        entry.src0        = rs_data;
        entry.src1        = sext16(imm_s);
      end
      OPC_ANDI: begin
        entry.illegal     = 1'b0;
        entry.alu_control = ALU_AND;
        entry.src0        = rs_data;
        entry.src1        = zext16(imm_s);
      end
      OPC_ORI: begin
        entry.illegal     = 1'b0;
        entry.alu_control = ALU_OR;
        entry.src0        = rs_data;
        entry.src1        = zext16(imm_s);
      end
      OPC_XORI: begin
        entry.illegal     = 1'b0;
        entry.alu_control = ALU_XOR;
        entry.src0        = rs_data;
        entry.src1        = zext16(imm_s);
      end
      OPC_LUI: begin
        entry.illegal     = 1'b0;
        entry.alu_control = ALU_LUI;
        entry.src0        = 32'h0;
        entry.src1        = zext16(imm_s);
      end
      default: entry = ENTRY_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// Decode/issue stage: decodes on entry, then buffers up to two decoded ops in a
// head/skid pair so in_ready never depends combinationally on out_ready.
module alu_op_issue
  import alu_op_issue_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  alu_op_issue_if.slave bus
);

  issue_entry_t dec_s;
  issue_entry_t head_r, head_nxt_s;
  issue_entry_t skid_r, skid_nxt_s;
  logic [1:0]   count_r, count_nxt_s;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         push_s;
  logic         pop_s;

  alu_op_decode u_decode (
    .instr   (bus.instr),
    .pc      (bus.pc),
    .rs_data (bus.rs_data),
    .rt_data (bus.rt_data),
    .entry   (dec_s)
  );

  assign push_s = bus.in_valid && in_ready_r;
  assign pop_s  = out_valid_r && bus.out_ready;

  // Next-state of the head/skid buffer; head is always the oldest entry
  always_comb begin
    head_nxt_s  = head_r;
    skid_nxt_s  = skid_r;
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_nxt_s = dec_s;
          end else begin
            skid_nxt_s = dec_s;
          end
          count_nxt_s = count_r + 2'd1;
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_nxt_s = skid_r;
          end else begin
            head_nxt_s = head_r;
          end
          count_nxt_s = count_r - 2'd1;
        end
        // push with pop only happens at count 1, so the new op replaces head
        2'b11: begin
          head_nxt_s  = dec_s;
          count_nxt_s = count_r;
        end
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Buffer state and registered handshake flags
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r      <= ENTRY_RESET;
      skid_r      <= ENTRY_RESET;
      count_r     <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      head_r      <= head_nxt_s;
      skid_r      <= skid_nxt_s;
      count_r     <= count_nxt_s;
      in_ready_r  <= (count_nxt_s < DEPTH);
      out_valid_r <= (count_nxt_s != 2'd0);
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.ALU_control = head_r.alu_control;
  assign bus.src0        = head_r.src0;
  assign bus.src1        = head_r.src1;
  assign bus.ov_en       = head_r.ov_en;
  assign bus.illegal     = head_r.illegal;

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Decode/issue stage that sits in front of the 6-bit-opcode ALU and drives its control/operand interface.
- Takes a fetched MIPS instruction plus its register-file read data and PC. Encodes the ALU opcode and selects and extends operands `src0`/`src1`.
- Presents the result to the ALU side through a 2-entry valid/ready buffer, so upstream and downstream stalls decouple without a combinational ready path.

Parameters:
- DEPTH, 2, output buffer entries. Fixed at 2 (skid). Other values are unsupported.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered entries this cycle (branch/exception redirect)
- in_valid  in  1  upstream entry valid
- in_ready  out  1  buffer can accept this cycle
- instr  in  32  instruction word
- pc  in  32  address of instr
- rs_data  in  32  GPR[rs]
- rt_data  in  32  GPR[rt]
- out_valid  out  1  issued op valid
- out_ready  in  1  ALU side accepts
- ALU_control  out  6  ALU opcode
- src0  out  32  first operand (shift amount for shifts, pc+4 hi bits for JUMP)
- src1  out  32  second operand
- ov_en  out  1  trap on overflow (ADD, SUB, ADDI only)
- illegal  out  1  undecodable instruction (ALU_control = NOP)

Behaviour:
- Reset: `reset` high at a rising edge clears both entries.
  - `out_valid`=0, `in_ready`=1.
  - `ALU_control`=NOP (0x3F); `src0`, `src1`=0; `ov_en`, `illegal`=0.
- Handshakes:
  - Accept on `in_valid && in_ready`. Issue on `out_valid && out_ready`.
  - `in_ready` = (count<2), registered-derived, with no combinational dependence on `out_ready`.
- Latency: an entry accepted in cycle N is visible on the outputs in cycle N+1 if the buffer was empty.
- Ordering and stability: FIFO order is preserved. Outputs are held stable while `out_valid && !out_ready`.
- Count update:
  - Simultaneous accept and issue: count unchanged.
  - count=2: `in_ready`=0.
  - count=0: `out_valid`=0 and outputs keep their last values.
- `flush`: count←0 next cycle. An accept in the same cycle is dropped. `flush` has priority over accept and issue. `reset` has priority over `flush`.
- Decode (opcode = `instr`[31:26], funct = `instr`[5:0], imm = `instr`[15:0], shamt = `instr`[10:6]):
  - R-type shifts (funct 00 SLL, 02 SRL, 03 SRA): `src0`={27'b0,shamt}, `src1`=`rt_data`.
  - Variable shifts (funct 04 SLLV, 06 SRLV, 07 SRAV): `src0`=`rs_data`, `src1`=`rt_data`.
  - Other R-type (funct 20 ADD, 21 ADDU, 22 SUB, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU): `src0`=`rs_data`, `src1`=`rt_data`.
  - ADDI 08 → ADD; ADDIU 09 → ADDU; SLTI 0A → SLT; SLTIU 0B → SLTU. All use sign-extended imm.
  - ANDI 0C, ORI 0D, XORI 0E: zero-extended imm. `src0`=`rs_data`.
  - LUI 0F: `src1`={16'b0,imm}, `src0`=0.
  - J 02 / JAL 03: JUMP. `src0`=`pc`+4, `src1`={4'b0,`instr`[25:0],2'b00}.
  - Anything else: NOP, `illegal`=1, operands 0.
- Decode is combinational on the input side. Only the decoded fields (6+32+32+1+1 bits) are stored per entry.

Decomposition:
- Shared package/include holds the ALU opcode constants:
  - ADD 00, ADDU 01, SUB 02, SUBU 03, SLL 04, SLLV 05, SRA 06, SRAV 07, SRL 08, SRLV 09
  - AND 0A, OR 0B, XOR 0C, NOR 0D, SLT 0E, SLTU 0F, SGT 10, SGTU 11, LUI 12, JUMP 13, NOP 3F
  - Also the MIPS opcode/funct constants.
- One sub-module: `alu_op_decode`, purely combinational, mapping instr/pc/rs/rt to the entry fields. The top keeps the 2-entry buffer and handshake.

Test Plan:
- ADDI rt,rs,0xFFFF with `rs_data`=5, `out_ready`=1 → next cycle `ALU_control`=00, `src0`=5, `src1`=0xFFFFFFFF, `ov_en`=1.
- SRA with shamt=4, `rt_data`=0x80000000 → `ALU_control`=06, `src0`=4, `src1`=0x80000000, `ov_en`=0.
- J target 0x0000010, `pc`=0x40000000 → `ALU_control`=13, `src0`=0x40000004, `src1`=0x00000040.
- Hold `out_ready`=0, push 3 ORI ops → `in_ready`=0 after 2 accepts, third held. Release → outputs in order, one per cycle, `in_ready`=1 the cycle after the first issue.
- Buffer holding 2 entries, assert `flush` with `in_valid`=1 → next cycle `out_valid`=0, count 0, flushed-cycle input not issued.
- opcode 0x3F → `illegal`=1, `ALU_control`=3F. Then `reset` high mid-stream → `out_valid`=0, `in_ready`=1 next cycle.
